mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Data-memory access stage of the MIPS pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns the MemRead/MemWrite control bits and the ALU-computed address into a req/ack transaction on the data-memory bus. It stalls the pipeline while the memory is busy and presents registered load data (`readData`) for the MEM/WB register to capture.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 15: cycles `memReq` may stay high without `memAck` before the request is aborted (used only with the timeout macro; legal range 1..255).

Ports:
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `M`  in  2  memory control from EX/MEM: `M[0]`=MemRead, `M[1]`=MemWrite.
- `AluResult`  in  32  effective address.
- `writeData`  in  32  store data (rt value).
- `readData`  out  32  registered load data to MEM/WB.
- `stall`  out  1  freeze PC/IF_ID/ID_EX/EX_MEM and bubble MEM/WB.
- `memReq`  out  1  bus request.
- `memWe`  out  1  1 = write, 0 = read; valid while `memReq`=1.
- `memAddr`  out  32  word address, `{AluResult[31:2],2'b00}`.
- `memWdata`  out  32  equals `writeData`.
- `memAck`  in  1  transfer completes at a rising edge where `memReq`=1 and `memAck`=1.
- `memRdata`  in  32  read data, valid with `memAck`.
- `busError`  out  1  sticky timeout flag.

## Operation
- **Op present:** `op` = `M[0]|M[1]`.
- **Write priority:** if both bits are set, the access is a write (`memWe`=1) and `readData` is not updated.
- **FSM states:** IDLE, WAIT, DONE.
- **IDLE:**
  - If `op`=1: `memReq`=1 and `stall`=1 combinationally.
  - Ack seen at the edge → DONE.
  - No ack → WAIT.
- **WAIT:** `memReq`=1 and `stall`=1. Ack → DONE.
- **DONE:** `memReq`=0 and `stall`=0, so the pipeline advances at the end of this cycle. Next state is always IDLE.
- **Completion edge:** if the access is a read, `readData <= memRdata`. Otherwise `readData` holds its value.
- **Combinational outputs:** `memAddr`, `memWdata` and `memWe` are combinational from the inputs. Upstream is stalled, so they are stable for the whole request.
- **Stray ack:** `memAck` while `memReq`=0 is ignored.
- **Back-to-back ops:** each op takes its own IDLE→…→DONE sequence. There is no overlap.
- **Reset values:** state=IDLE, `readData`=0, `busError`=0. While `rst`=1, `memReq`=0 and `stall`=0 regardless of state.
- **Reset mid-transaction:** the request is abandoned, and a late ack is ignored.

## Timing
- **Zero-wait memory:** `stall` high 1 cycle; the op occupies 2 cycles (IDLE, DONE).
- **N wait states:** `stall` high N+1 cycles; `memReq` high N+1 cycles.
- **`readData` timing:** valid from the DONE cycle onward and held until the next read completes.
- **Non-memory instructions:** `stall`=0 and `memReq`=0, with zero added latency.

## Configuration
- Macro `MEM_ACCESS_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter clears on entry to a request and increments each cycle that `memReq`=1 and `memAck`=0.
  - When it equals `TIMEOUT_CYCLES`, the request is aborted at that edge: state → DONE, `readData <= 32'h0` if the access is a read, `busError <= 1` (sticky until `rst`).
  - If ack and timeout coincide on the same edge, the ack wins: normal completion, no error.
- **Not defined:**
  - No counter; a request waits indefinitely.
  - `busError` is tied to 0. The port list is unchanged.

## Structure
- **Shared package `mips_pkg`:**
  - FSM state typedef (IDLE/WAIT/DONE).
  - `MEM_READ_BIT`=0, `MEM_WRITE_BIT`=1.
  - Word-alignment mask constant.
- **Sub-module `mem_timeout_counter`:** counter plus compare, instantiated only under `MEM_ACCESS_TIMEOUT_EN`.

## Test plan
- **Zero-wait load:** `M`=2'b01, `AluResult`=32'h0000_0013, ack same cycle with `memRdata`=32'hCAFE_0001 → `memAddr`=32'h10, `stall`=1 for 1 cycle, `readData`=32'hCAFE_0001 in the DONE cycle.
- **Store with 3 wait states:** `M`=2'b10, `writeData`=32'h1234_5678 → `memWe`=1 and `memWdata`=32'h1234_5678 for 4 cycles, `stall`=1 for 4 cycles, `readData` unchanged.
- **Both bits set plus stray ack:** `M`=2'b11 → treated as a write. A stray `memAck` pulse while idle with `M`=2'b00 produces no state change.
- **Reset mid-request:** `rst` asserted in WAIT → next cycle state=IDLE, `memReq`=0, `stall`=0, `readData`=0. A late ack is ignored.
- **Timeout (macro on, `TIMEOUT_CYCLES`=4):** load with no ack → abort after 4 cycles, `busError`=1 (sticky), `readData`=0. Ack on the 4th edge instead → normal completion, `busError`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory-stage FSM encoding, M-bus bit
// positions and the word-alignment mask.
package mips_pkg;

    typedef logic [1:0] mem_state_t;

    localparam mem_state_t ST_IDLE = 2'd0;
    localparam mem_state_t ST_WAIT = 2'd1;
    localparam mem_state_t ST_DONE = 2'd2;

    localparam int MEM_READ_BIT  = 0;
    localparam int MEM_WRITE_BIT = 1;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_timeout_counter.sv
// Watchdog for an outstanding data-memory request: counts unacknowledged
// request cycles and flags the edge on which the request must be aborted.
module mem_timeout_counter #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Idle cycles hold the count at zero, so every new request starts fresh.
    assign cnt_d    = (active_i && !ack_i) ? cnt_q + 8'd1 : 8'd0;
    assign expire_o = active_i && !ack_i && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS data-memory access stage: turns MemRead/MemWrite into a req/ack bus
// transaction, stalls the pipeline while busy. Optional watchdog: MEM_ACCESS_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no request outstanding; a memory op issues memReq this cycle
// WAIT  | request outstanding, waiting for memAck
// DONE  | transfer finished, pipeline advances at the end of this cycle
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  M,
    input  logic [31:0] AluResult,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        stall,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic        busError
);

    mem_state_t  state_q, state_d;
    logic [31:0] read_data_q, read_data_d;
    logic        op, is_read, req, ack_done, abort;

    assign op      = M[MEM_READ_BIT] | M[MEM_WRITE_BIT];
    assign is_read = M[MEM_READ_BIT] & ~M[MEM_WRITE_BIT];

    assign memWe    = M[MEM_WRITE_BIT];
    assign memAddr  = AluResult & WORD_ALIGN_MASK;
    assign memWdata = writeData;

    assign req      = !rst && ((state_q == ST_IDLE && op) || state_q == ST_WAIT);
    assign ack_done = req && memAck;

    assign memReq   = req;
    assign stall    = req;
    assign readData = read_data_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic bus_error_q;

    // Expiry is suppressed on an acked edge, so a coincident ack completes normally.
    mem_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .active_i(req),
        .ack_i   (memAck),
        .expire_o(abort)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_error_q <= 1'b0;
        end else if (abort) begin
            bus_error_q <= 1'b1;
        end
    end

    assign busError = bus_error_q;
`else
    logic [7:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES[7:0];
    assign abort          = 1'b0;
    assign busError       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (op) state_d = (ack_done || abort) ? ST_DONE : ST_WAIT;
            ST_WAIT: if (ack_done || abort) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        read_data_d = read_data_q;
        if (ack_done && is_read) begin
            read_data_d = memRdata;
        end else if (abort && is_read) begin
            read_data_d = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            read_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, write priority, stray
// ack, reset mid-request and (with MEM_ACCESS_TIMEOUT_EN) the watchdog.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  M;
    logic [31:0] AluResult;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        stall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memAck;
    logic [31:0] memRdata;
    logic        busError;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .M        (M),
        .AluResult(AluResult),
        .writeData(writeData),
        .readData (readData),
        .stall    (stall),
        .memReq   (memReq),
        .memWe    (memWe),
        .memAddr  (memAddr),
        .memWdata (memWdata),
        .memAck   (memAck),
        .memRdata (memRdata),
        .busError (busError)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled mid-cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    initial begin
        rst = 1'b1; M = 2'b01; AluResult = 32'h0; writeData = 32'h0;
        memAck = 1'b0; memRdata = 32'h0;
        next_cycle();
        next_cycle();
        mid();
        check("rst_memReq", {31'b0, memReq}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_readData", readData, 32'h0);
        check("rst_busError", {31'b0, busError}, 32'd0);

        // Zero-wait load
        next_cycle();
        rst = 1'b0; M = 2'b01; AluResult = 32'h0000_0013;
        memAck = 1'b1; memRdata = 32'hCAFE_0001;
        mid();
        check("ld0_memReq", {31'b0, memReq}, 32'd1);
        check("ld0_stall", {31'b0, stall}, 32'd1);
        check("ld0_memWe", {31'b0, memWe}, 32'd0);
        check("ld0_memAddr", memAddr, 32'h0000_0010);
        next_cycle();
        memAck = 1'b0; M = 2'b00;
        mid();
        check("ld0_done_stall", {31'b0, stall}, 32'd0);
        check("ld0_done_memReq", {31'b0, memReq}, 32'd0);
        check("ld0_readData", readData, 32'hCAFE_0001);
        next_cycle();
        mid();
        check("nop_stall", {31'b0, stall}, 32'd0);
        check("nop_readData_hold", readData, 32'hCAFE_0001);

        // Store with 3 wait states
        next_cycle();
        M = 2'b10; AluResult = 32'h0000_0102; writeData = 32'h1234_5678;
        memRdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            memAck = (i == 3);
            mid();
            check($sformatf("st_stall_%0d", i), {31'b0, stall}, 32'd1);
            check($sformatf("st_memWe_%0d", i), {31'b0, memWe}, 32'd1);
            check($sformatf("st_memWdata_%0d", i), memWdata, 32'h1234_5678);
            next_cycle();
        end
        memAck = 1'b0;
        mid();
        check("st_done_stall", {31'b0, stall}, 32'd0);
        check("st_readData_hold", readData, 32'hCAFE_0001);

        // Both bits set: write wins, readData untouched
        next_cycle();
        M = 2'b11; AluResult = 32'h0000_0200; memAck = 1'b1; memRdata = 32'h0BAD_F00D;
        mid();
        check("both_memWe", {31'b0, memWe}, 32'd1);
        check("both_stall", {31'b0, stall}, 32'd1);
        next_cycle();
        memAck = 1'b0; M = 2'b00;
        mid();
        check("both_done_stall", {31'b0, stall}, 32'd0);
        check("both_readData", readData, 32'hCAFE_0001);

        // Stray ack while idle
        next_cycle();
        memAck = 1'b1; memRdata = 32'h5555_5555;
        mid();
        check("stray_memReq", {31'b0, memReq}, 32'd0);
        check("stray_stall", {31'b0, stall}, 32'd0);
        next_cycle();
        memAck = 1'b0;
        mid();
        check("stray_readData", readData, 32'hCAFE_0001);
        check("stray_idle_stall", {31'b0, stall}, 32'd0);

        // Load with one wait state
        next_cycle();
        M = 2'b01; AluResult = 32'h0000_0FFF; memRdata = 32'hA5A5_0F0F;
        mid();
        check("ld1_stall_0", {31'b0, stall}, 32'd1);
        check("ld1_memAddr", memAddr, 32'h0000_0FFC);
        next_cycle();
        memAck = 1'b1;
        mid();
        check("ld1_stall_1", {31'b0, stall}, 32'd1);
        check("ld1_readData_pending", readData, 32'hCAFE_0001);
        next_cycle();
        memAck = 1'b0; M = 2'b00;
        mid();
        check("ld1_done_stall", {31'b0, stall}, 32'd0);
        check("ld1_readData", readData, 32'hA5A5_0F0F);

        // Reset while waiting, then a late ack
        next_cycle();
        M = 2'b01; AluResult = 32'h0000_0040; memRdata = 32'h7777_7777;
        next_cycle();
        mid();
        check("rstw_stall_wait", {31'b0, stall}, 32'd1);
        next_cycle();
        rst = 1'b1;
        mid();
        check("rstw_memReq_comb", {31'b0, memReq}, 32'd0);
        check("rstw_stall_comb", {31'b0, stall}, 32'd0);
        next_cycle();
        mid();
        check("rstw_readData", readData, 32'h0);
        next_cycle();
        rst = 1'b0; M = 2'b00; memAck = 1'b1;
        mid();
        check("late_ack_memReq", {31'b0, memReq}, 32'd0);
        check("late_ack_stall", {31'b0, stall}, 32'd0);
        next_cycle();
        memAck = 1'b0;
        mid();
        check("late_ack_readData", readData, 32'h0);

`ifdef MEM_ACCESS_TIMEOUT_EN
        // Preload a nonzero value, then a load that never gets acked
        next_cycle();
        M = 2'b01; AluResult = 32'h0000_0080; memAck = 1'b1; memRdata = 32'h1111_2222;
        next_cycle();
        memAck = 1'b0; M = 2'b00;
        mid();
        check("to_pre_readData", readData, 32'h1111_2222);
        next_cycle();
        M = 2'b01; memRdata = 32'h9999_9999;
        for (int i = 0; i < 4; i++) begin
            mid();
            check($sformatf("to_stall_%0d", i), {31'b0, stall}, 32'd1);
            check($sformatf("to_busError_pre_%0d", i), {31'b0, busError}, 32'd0);
            next_cycle();
        end
        M = 2'b00;
        mid();
        check("to_done_stall", {31'b0, stall}, 32'd0);
        check("to_busError", {31'b0, busError}, 32'd1);
        check("to_readData", readData, 32'h0);
        next_cycle();
        next_cycle();
        mid();
        check("to_busError_sticky", {31'b0, busError}, 32'd1);

        // Ack on the expiry edge wins
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; M = 2'b01; memRdata = 32'h4242_4242;
        for (int i = 0; i < 4; i++) begin
            memAck = (i == 3);
            mid();
            check($sformatf("ackwin_stall_%0d", i), {31'b0, stall}, 32'd1);
            next_cycle();
        end
        memAck = 1'b0; M = 2'b00;
        mid();
        check("ackwin_busError", {31'b0, busError}, 32'd0);
        check("ackwin_readData", readData, 32'h4242_4242);
`else
        // Without the watchdog an unacked request just keeps waiting
        next_cycle();
        M = 2'b01; AluResult = 32'h0000_0080;
        for (int i = 0; i < 8; i++) next_cycle();
        mid();
        check("nowd_stall", {31'b0, stall}, 32'd1);
        check("nowd_busError", {31'b0, busError}, 32'd0);
        next_cycle();
        memAck = 1'b1; memRdata = 32'h3333_4444;
        next_cycle();
        memAck = 1'b0; M = 2'b00;
        mid();
        check("nowd_readData", readData, 32'h3333_4444);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
